// File: rtl/csel_wide_add_seq_if.sv
// csel_wide_add_seq_if: start/busy/done operand and result bundle for the wide adder sequencer
// master drives start, sub, a, b, cin; slave returns busy, done, sum, cout, ovf
interface csel_wide_add_seq_if #(parameter int WORDS = 4);
   localparam int W = 16 * WORDS;
   logic         start, sub, cin, busy, done, cout, ovf;
   logic [W-1:0] a, b, sum;
   modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/csel_wide_add_seq.sv
// csel_wide_add_seq: 16*WORDS-bit add/sub computed one 16-bit slice per cycle on one carry-select adder
// clk, rst (async, active-high); io.start/sub/a/b/cin in; io.busy/done/sum/cout/ovf out, all registered
module c_select16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [4:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < 4; i++) begin : g_blk
      logic [4:0] r0, r1;
      // both carry hypotheses are computed up front; the incoming carry only selects
      assign r0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
      assign r1 = r0 + 5'd1;
      assign s[4*i +: 4] = c[i] ? r1[3:0] : r0[3:0];
      assign c[i+1] = c[i] ? r1[4] : r0[4];
   end
   assign cout = c[4];
endmodule

module csel_wide_add_seq #(parameter int WORDS = 4) (
   input logic clk,
   input logic rst,
   csel_wide_add_seq_if.slave io
);
   localparam int W = 16 * WORDS;
   localparam int IW = $clog2(WORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state_q, state_d;
   logic [W-1:0]  opa, opb;
   logic [W-17:0] acc;
   logic [IW-1:0] idx;
   logic [15:0]   s;
   logic          carry, co, last, take;
   c_select16bit u_add (.a(opa[16*idx +: 16]), .b(opb[16*idx +: 16]), .cin(carry), .s(s), .cout(co));
   always_comb begin
      last = idx == IW'(WORDS - 1);
      take = io.start && state_q != RUN;
      state_d = take ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opa     <= '0;
         opb     <= '0;
         acc     <= '0;
         idx     <= '0;
         carry   <= 1'b0;
         io.busy <= 1'b0;
         io.done <= 1'b0;
         io.sum  <= '0;
         io.cout <= 1'b0;
         io.ovf  <= 1'b0;
      end else begin
         state_q <= state_d;
         io.busy <= state_d == RUN;
         io.done <= state_d == DONE;
         if (take) begin
            // subtract is a + ~b + 1, so the carry seeds with 1 and cin is dropped
            opa   <= io.a;
            opb   <= io.sub ? ~io.b : io.b;
            carry <= io.sub | io.cin;
            idx   <= '0;
         end else if (state_q == RUN) begin
            carry <= co;
            idx   <= idx + 1'b1;
            if (last) begin
               // top slice goes straight to the result, so acc never holds it
               io.sum  <= {s, acc};
               io.cout <= co;
               io.ovf  <= (opa[W-1] == opb[W-1]) && (s[15] != opa[W-1]);
            end else begin
               acc[16*idx +: 16] <= s;
            end
         end
      end
   end
endmodule

// File: doc/csel_wide_add_seq.md
# csel_wide_add_seq

Multi-cycle wide adder/subtractor sequencer built around one internal `c_select16bit` carry-select adder instance. It accepts `16*WORDS`-bit operands with a start/busy/done handshake. It feeds the adder one 16-bit slice per cycle, least-significant slice first, chaining the carry through a register. Full-width sum, carry-out and signed overflow are published together when the operation completes. It lets the datapath do 32/48/64-bit arithmetic without replicating the 16-bit adder.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit slices; operand width `W = 16*WORDS`; legal range 2..16.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — operation request; sampled only when `busy`=0.
- `sub`  in  1  — 0 = add `a+b+cin`; 1 = subtract `a-b` (`cin` ignored).
- `a`  in  W  — operand A; captured on accepted `start`.
- `b`  in  W  — operand B; captured on accepted `start`.
- `cin`  in  1  — carry-in for add; captured on accepted `start`.
- `busy`  out  1  — high while slices are being computed.
- `done`  out  1  — one-cycle pulse; `sum`/`cout`/`ovf` update on the same edge.
- `sum`  out  W  — result; holds until the next `done`.
- `cout`  out  1  — carry out of the MSB slice. For `sub`, 1 = no borrow.
- `ovf`  out  1  — two's-complement signed overflow of the full-width result.

## Operation
FSM states: IDLE, RUN, DONE.
- **IDLE**: `busy`=0.
  - On `start`=1, capture `a` into `opa`.
  - Capture `b` into `opb`, inverted bitwise if `sub`=1.
  - Set `carry` to `sub ? 1 : cin`, `idx` to 0.
  - Go to RUN.
- **RUN**: `busy`=1.
  - The adder receives `opa[16*idx +: 16]`, `opb[16*idx +: 16]`, `carry`.
  - On each edge: store the adder `s` into accumulator slice `idx`, set `carry` to the adder `cout`, increment `idx`.
  - When the slice with `idx`=WORDS-1 is stored, go to DONE.
- **DONE**: `done`=1, `busy`=0 for exactly one cycle.
  - Outputs were loaded on the entering edge: `sum` = accumulator, `cout` = final carry.
  - `ovf` = (`opa[W-1]` == `opb[W-1]`) && (`sum[W-1]` != `opa[W-1]`), using the effective (possibly inverted) `opb`.
  - If `start`=1 in DONE, capture new operands exactly as from IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor able to alter the operands.
- Operand inputs may change freely after capture.
- Arithmetic is modulo 2^W. `cout`/`ovf` are the only out-of-range indicators.
- No combinational path from inputs to outputs. All outputs are registered.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, state IDLE, `idx`=0, `carry`=0.
- `start` is accepted at edge E0. `busy` is high after E0.
- Slice i is computed in cycle E(i)..E(i+1); the last slice is stored at edge E(WORDS).
- `done` and the new results are visible after E(WORDS). Latency start→done = WORDS edges; WORDS=4 gives 4.
- `done` falls after E(WORDS+1).
- Back-to-back throughput: one result per WORDS+1 cycles. `start` held continuously yields `done` every WORDS+1 cycles.
- Reset mid-RUN or mid-DONE:
  - All state and outputs go to reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and no `done` is produced.
  - The first `start` is accepted at the first edge after `rst` deasserts.

## Test plan
All scenarios use WORDS=4 (64-bit).
- **Reset**: assert `rst` with random inputs → `busy`,`done`,`sum`,`cout`,`ovf` all 0. Hold `start`=1 during reset → no operation begins.
- **Cross-slice carry**: `a`=0x0000_0000_0000_FFFF, `b`=1, `cin`=0, add. Expect `sum`=0x0000_0000_0001_0000, `cout`=0, `ovf`=0. `done` pulses exactly 4 edges after the start edge, width 1 cycle.
- **Full ripple**: `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0, `cin`=1, add → `sum`=0, `cout`=1, `ovf`=0.
- **Subtract**: `a`=5, `b`=7, `sub`=1, `cin`=0 → `sum`=0xFFFF_FFFF_FFFF_FFFE, `cout`=0, `ovf`=0. Then `a`=7, `b`=5 → `sum`=2, `cout`=1, `ovf`=0.
- **Signed overflow**: `a`=0x7FFF_FFFF_FFFF_FFFF, `b`=1, add → `sum`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0. Also `a`=0x8000_0000_0000_0000, `b`=1, `sub`=1 → `sum`=0x7FFF_FFFF_FFFF_FFFF, `ovf`=1, `cout`=1.
- **Handshake corners**:
  - Pulse `start` with new operands during RUN → ignored; the result matches the original operands.
  - Assert `start` in the DONE cycle → next `done` exactly 5 cycles after the previous one, with the second result correct.
  - Assert `rst` at slice 2 → no `done`, outputs 0; a new operation after reset computes correctly.
